// File: rtl/freq_meter.sv
// ---------------------------------------------------------------------------
// freq_meter
// Counts rising edges of an asynchronous square wave over a gate window of
// GATE_CYCLES clk periods and publishes the count on freq_out with a one-cycle
// valid strobe. With a 50 MHz clk and the default 50_000_000-cycle gate the
// published count reads directly in Hz.
//
// Optional feature macro: FREQ_METER_HOLD_EN
//   When defined, adds input `hold`. While hold=1 at a window end, freq_out and
//   overflow keep their values and valid stays low; measuring continues.
// ---------------------------------------------------------------------------
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,  // clk cycles per window (>= 2)
    parameter int CNT_W       = 26,          // edge counter / freq_out width
    parameter int SYNC_STAGES = 2            // synchronizer depth (>= 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
`ifdef FREQ_METER_HOLD_EN
    input  logic             hold,
`endif
    output logic [CNT_W-1:0] freq_out,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam int                FILL_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    state_t                 r_state;
    logic [FILL_W-1:0]      r_fill;
    logic [GATE_W-1:0]      r_gate_cnt;
    logic [CNT_W-1:0]       r_edge_cnt;
    logic                   r_sat;
    logic [CNT_W-1:0]       r_freq;
    logic                   r_valid;
    logic                   r_overflow;
    logic                   r_busy;

    logic                   w_edge;
    logic                   w_drop;
    logic [CNT_W-1:0]       w_next_cnt;
    logic                   w_next_sat;
    logic                   w_publish;

    // Synchronize sig_in into clk and keep one extra flop for edge detection.
    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge value of its neighbours and the chain shifts by one stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

`ifdef FREQ_METER_HOLD_EN
    assign w_publish = ~hold;
`else
    assign w_publish = 1'b1;
`endif

    // Saturating edge accumulation; a dropped edge at full scale marks the window saturated.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_drop     = 1'b0;
        w_next_cnt = r_edge_cnt;
        w_next_sat = r_sat;
        if (w_edge) begin
            if (r_edge_cnt == CNT_MAX) begin
                w_drop = 1'b1;
            end else begin
                w_next_cnt = r_edge_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
        w_next_sat = r_sat | w_drop;
    end

    // Control FSM: pipeline fill after reset, idle, and back-to-back gate windows.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_FILL;
            r_fill     <= '0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            r_freq     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                // Let the synchronizer and edge flop settle so a line that is
                // already high at reset is not seen as a rising edge.
                ST_FILL: begin
                    if (r_fill == FILL_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_fill <= r_fill + {{(FILL_W-1){1'b0}}, 1'b1};
                    end
                end

                ST_IDLE: begin
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_sat      <= 1'b0;
                    if (enable) begin
                        r_state <= ST_MEASURE;
                        r_busy  <= 1'b1;
                    end
                end

                ST_MEASURE: begin
                    if (r_gate_cnt == GATE_LAST) begin
                        // The edge seen on the final gate cycle still belongs to
                        // this window; the next cycle opens a fresh one.
                        if (w_publish) begin
                            r_freq     <= w_next_cnt;
                            r_overflow <= w_next_sat;
                            r_valid    <= 1'b1;
                        end
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_sat      <= 1'b0;
                        if (!enable) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (!enable) begin
                        // Abort: the partial count is thrown away.
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_sat      <= 1'b0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + {{(GATE_W-1){1'b0}}, 1'b1};
                        r_edge_cnt <= w_next_cnt;
                        r_sat      <= w_next_sat;
                    end
                end

                default: begin
                    r_state <= ST_FILL;
                    r_fill  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign freq_out = r_freq;
    assign valid    = r_valid;
    assign overflow = r_overflow;
    assign busy     = r_busy;

endmodule

// File: tb/tb_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_freq_meter
// Two freq_meter instances (CNT_W=8 and CNT_W=5, GATE_CYCLES=100) share one
// stimulus stream. A reference model works from sampled sig_in values and
// window bookkeeping, pushes the expected result of every completed window
// into a per-instance queue, and a monitor pops on valid and compares.
// Build with +define+FREQ_METER_HOLD_EN to exercise the hold input.
// ---------------------------------------------------------------------------
module tb_freq_meter;

    localparam int G  = 100;
    localparam int S  = 2;
    localparam int W8 = 8;
    localparam int W5 = 5;

    typedef struct {
        int freq;
        bit ov;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          sig_in;
    logic          hold;
    logic [W8-1:0] freq8;
    logic [W5-1:0] freq5;
    logic          valid8, valid5, ov8, ov5, busy8, busy5;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(W8), .SYNC_STAGES(S)) dut8 (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sig_in   (sig_in),
`ifdef FREQ_METER_HOLD_EN
        .hold     (hold),
`endif
        .freq_out (freq8),
        .valid    (valid8),
        .overflow (ov8),
        .busy     (busy8)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(W5), .SYNC_STAGES(S)) dut5 (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sig_in   (sig_in),
`ifdef FREQ_METER_HOLD_EN
        .hold     (hold),
`endif
        .freq_out (freq5),
        .valid    (valid5),
        .overflow (ov5),
        .busy     (busy5)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    exp_t q8[$];
    exp_t q5[$];
    bit   hist[$];          // hist[0] = sig_in sampled at the latest posedge
    bit   armed     = 0;
    int   fill_left = 0;
    bit   meas      = 0;
    int   pos       = 0;
    int   cnt       = 0;
    int   lf8 = 0, lf5 = 0;
    bit   lo8 = 0, lo5 = 0;

    function automatic exp_t sat_result(input int c, input int w);
        exp_t e;
        int   mx;
        mx     = (1 << w) - 1;
        e.freq = (c > mx) ? mx : c;
        e.ov   = (c > mx);
        return e;
    endfunction

    // Called right after each posedge with the inputs that edge sampled.
    task automatic model_step();
        bit   e;
        bit   h;
        exp_t r8, r5;
        hist.push_front(sig_in);
        void'(hist.pop_back());
        // A rising edge at the pin is counted SYNC_STAGES posedges after it is sampled.
        e = hist[S] && !hist[S+1];
`ifdef FREQ_METER_HOLD_EN
        h = hold;
`else
        h = 1'b0;
`endif
        if (reset) begin
            armed     = 1;
            fill_left = S + 1;
            meas      = 0;
            lf8 = 0; lf5 = 0; lo8 = 0; lo5 = 0;
            q8.delete();
            q5.delete();
            return;
        end
        if (fill_left > 0) begin
            fill_left--;
            return;
        end
        if (!meas) begin
            if (enable) begin
                meas = 1;
                pos  = 0;
                cnt  = 0;
            end
            return;
        end
        cnt += int'(e);
        pos++;
        if (pos == G) begin
            if (!h) begin
                r8 = sat_result(cnt, W8);
                r5 = sat_result(cnt, W5);
                q8.push_back(r8);
                q5.push_back(r5);
                lf8 = r8.freq; lo8 = r8.ov;
                lf5 = r5.freq; lo5 = r5.ov;
            end
            pos = 0;
            cnt = 0;
            if (!enable) meas = 0;
        end else if (!enable) begin
            meas = 0;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            check("valid8", {31'd0, valid8}, {31'd0, q8.size() > 0});
            if (q8.size() > 0) begin
                e = q8.pop_front();
                if (valid8) begin
                    check("win_freq8", 32'(freq8), e.freq);
                    check("win_ovf8", {31'd0, ov8}, {31'd0, e.ov});
                end
            end
            check("valid5", {31'd0, valid5}, {31'd0, q5.size() > 0});
            if (q5.size() > 0) begin
                e = q5.pop_front();
                if (valid5) begin
                    check("win_freq5", 32'(freq5), e.freq);
                    check("win_ovf5", {31'd0, ov5}, {31'd0, e.ov});
                end
            end
            check("freq8", 32'(freq8), lf8);
            check("ovf8", {31'd0, ov8}, {31'd0, lo8});
            check("freq5", 32'(freq5), lf5);
            check("ovf5", {31'd0, ov5}, {31'd0, lo5});
            check("busy8", {31'd0, busy8}, {31'd0, meas});
            check("busy5", {31'd0, busy5}, {31'd0, meas});
        end
    end

    // ---------------- stimulus ----------------
    bit drv_rst  = 1;
    bit drv_en   = 0;
    bit drv_hold = 0;
    int per      = 10;   // 0 = constant level
    bit lvl      = 0;
    bit rnd      = 0;
    int ph       = 0;

    task automatic tick();
        @(negedge clk);
        reset  = drv_rst;
        enable = drv_en;
        hold   = drv_hold;
        if (rnd)           sig_in = 1'($urandom_range(0, 1));
        else if (per == 0) sig_in = lvl;
        else               sig_in = ((ph % per) < (per / 2));
        ph++;
        @(posedge clk);
        model_step();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        hold   = 1'b0;
        for (int i = 0; i < S + 2; i++) hist.push_back(1'b0);

        // Period-10 input, continuous windows: 10 per window, no overflow.
        drv_rst = 1; drv_en = 1; per = 10;
        run(4);
        drv_rst = 0;
        run(3 * G + 20);

        // Input already high through reset: first window must read 0.
        drv_rst = 1; drv_en = 0; per = 0; lvl = 1;
        run(3);
        drv_rst = 0;
        run(10);
        drv_en = 1;
        run(G + 10);

        // Toggle every clk: 50 edges saturates the 5-bit instance, then back to period 10.
        per = 2;
        run(2 * G);
        per = 10;
        run(2 * G);

        // Abort mid-window, idle, then a full window after re-enable.
        run(50);
        drv_en = 0;
        run(20);
        drv_en = 1;
        run(G + 20);

        // Reset in the middle of a window.
        run(40);
        drv_rst = 1;
        run(1);
        drv_rst = 0;
        run(G + 30);

`ifdef FREQ_METER_HOLD_EN
        // Hold across two windows while the rate changes from 10 to 20 edges.
        per = 10;
        run(G + 10);
        drv_hold = 1; per = 5;
        run(2 * G + 10);
        drv_hold = 0;
        run(G + 10);
`endif

        // Randomized segments: rate, pattern, enable drops and occasional resets.
        for (int seg = 0; seg < 30; seg++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            rnd  = (kind == 0);
            per  = (kind == 1) ? 0 : int'($urandom_range(2, 40));
            lvl  = 1'($urandom_range(0, 1));
            drv_en = ($urandom_range(0, 4) != 0);
`ifdef FREQ_METER_HOLD_EN
            drv_hold = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 9) == 0) begin
                drv_rst = 1;
                run(int'($urandom_range(1, 3)));
                drv_rst = 0;
            end
            run(int'($urandom_range(30, 250)));
        end

        drv_en = 0; drv_hold = 0;
        run(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
